// File: rtl/cpu_log_formatter_if.sv
// cpu_log_formatter_if
//   Record-in / character-out bus of the trace-line formatter.
//   Record side : in_valid/in_ready handshake with the record fields
//                 in_kind, in_time, in_pc, in_grf, in_addr, in_data.
//   Char side   : out_valid/out_ready handshake carrying out_char, with
//                 out_last marking the final '#' of each line.
//   slave  modport : the formatter (takes records, produces characters).
//   master modport : the environment (offers records, sinks characters).
interface cpu_log_formatter_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_kind;
  logic [13:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_grf;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_char;
  logic        out_last;

  modport slave (
    input  in_valid, in_kind, in_time, in_pc, in_grf, in_addr, in_data,
    output in_ready,
    output out_valid, out_char, out_last,
    input  out_ready
  );

  modport master (
    output in_valid, in_kind, in_time, in_pc, in_grf, in_addr, in_data,
    input  in_ready,
    input  out_valid, out_char, out_last,
    output out_ready
  );
endinterface

// File: rtl/cpu_log_formatter.sv
// cpu_log_formatter
//   Turns one CPU write-back record into an ASCII trace line, one character
//   per accepted output beat:
//     register write : ^TIME@PC: $GRF <= DATA#
//     memory write   : ^TIME@PC: *ADDR <= DATA#
//   TIME and GRF are decimal without leading zeros (TIME saturates at 9999);
//   PC, ADDR and DATA are 8 lowercase hex digits.
// Ports
//   clk   : clock, all state on rising edge
//   reset : asynchronous, active-low
//   bus   : cpu_log_formatter_if.slave (record input + character output)
module cpu_log_formatter (
  input  logic                  clk,
  input  logic                  reset,
  cpu_log_formatter_if.slave    bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CARET,
    S_TIME,
    S_AT,
    S_PC,
    S_COLON,
    S_SPACE,
    S_SIGIL,
    S_REGNUM,
    S_ADDR,
    S_ARROW,
    S_DATA,
    S_HASH
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  idx;

  // Record latched on acceptance; decimal fields are stored already
  // converted to BCD so the character mux only selects nibbles.
  logic        kind_r;
  logic [15:0] time_bcd;
  logic [2:0]  time_ndig;
  logic [7:0]  grf_bcd;
  logic [1:0]  grf_ndig;
  logic [31:0] pc_r;
  logic [31:0] addr_r;
  logic [31:0] data_r;

  logic        accept;
  logic        fire;
  logic        last_in_state;
  logic [2:0]  time_pos;
  logic [1:0]  grf_pos;
  logic [3:0]  time_nib;
  logic [3:0]  grf_nib;

  function automatic logic [13:0] sat_time(input logic [13:0] t);
    return (t > 14'd9999) ? 14'd9999 : t;
  endfunction

  function automatic logic [15:0] time_to_bcd(input logic [13:0] t);
    logic [13:0] d3, d2, d1, d0;
    d3 = t / 14'd1000;
    d2 = (t / 14'd100) % 14'd10;
    d1 = (t / 14'd10) % 14'd10;
    d0 = t % 14'd10;
    return {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
  endfunction

  function automatic logic [2:0] time_digits(input logic [13:0] t);
    if (t >= 14'd1000)     return 3'd4;
    else if (t >= 14'd100) return 3'd3;
    else if (t >= 14'd10)  return 3'd2;
    else                   return 3'd1;
  endfunction

  function automatic logic [7:0] grf_to_bcd(input logic [4:0] g);
    logic [4:0] hi, lo;
    hi = g / 5'd10;
    lo = g % 5'd10;
    return {hi[3:0], lo[3:0]};
  endfunction

  function automatic logic [7:0] dec_char(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    // 'a' - 10 = 8'h57
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Hex fields go MSB first: digit index 0 is bits [31:28].
  function automatic logic [3:0] nibble(input logic [31:0] w, input logic [2:0] i);
    logic [31:0] sh;
    sh = w >> {3'd7 - i, 2'b00};
    return sh[3:0];
  endfunction

  assign accept = bus.in_valid && (state == S_IDLE);
  assign fire   = (state != S_IDLE) && bus.out_ready;

  // ---- record capture ----
  always_ff @(posedge clk) begin
    if (accept) begin
      kind_r    <= bus.in_kind;
      time_bcd  <= time_to_bcd(sat_time(bus.in_time));
      time_ndig <= time_digits(sat_time(bus.in_time));
      grf_bcd   <= grf_to_bcd(bus.in_grf);
      grf_ndig  <= (bus.in_grf >= 5'd10) ? 2'd2 : 2'd1;
      pc_r      <= bus.in_pc;
      addr_r    <= bus.in_addr;
      data_r    <= bus.in_data;
    end
  end

  // ---- state register and digit index ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) idx <= 3'd0;
      else if (fire)          idx <= idx + 3'd1;
    end
  end

  // Leading zeros are skipped by offsetting the index, so idx 0 always
  // lands on the first significant digit.
  assign time_pos = idx + (3'd4 - time_ndig);
  assign grf_pos  = idx[1:0] + (2'd2 - grf_ndig);

  always_comb begin
    time_nib = 4'h0;
    case (time_pos)
      3'd0:    time_nib = time_bcd[15:12];
      3'd1:    time_nib = time_bcd[11:8];
      3'd2:    time_nib = time_bcd[7:4];
      3'd3:    time_nib = time_bcd[3:0];
      default: time_nib = 4'h0;
    endcase
  end

  assign grf_nib = grf_pos[0] ? grf_bcd[3:0] : grf_bcd[7:4];

  always_comb begin
    last_in_state = 1'b1;
    case (state)
      S_TIME:   last_in_state = (idx == time_ndig - 3'd1);
      S_REGNUM: last_in_state = (idx[1:0] == grf_ndig - 2'd1);
      S_PC,
      S_ADDR,
      S_DATA:   last_in_state = (idx == 3'd7);
      S_ARROW:  last_in_state = (idx == 3'd3);
      default:  last_in_state = 1'b1;
    endcase
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    if (state == S_IDLE) begin
      if (bus.in_valid) state_nxt = S_CARET;
    end else if (fire && last_in_state) begin
      case (state)
        S_CARET:  state_nxt = S_TIME;
        S_TIME:   state_nxt = S_AT;
        S_AT:     state_nxt = S_PC;
        S_PC:     state_nxt = S_COLON;
        S_COLON:  state_nxt = S_SPACE;
        S_SPACE:  state_nxt = S_SIGIL;
        S_SIGIL:  state_nxt = kind_r ? S_ADDR : S_REGNUM;
        S_REGNUM: state_nxt = S_ARROW;
        S_ADDR:   state_nxt = S_ARROW;
        S_ARROW:  state_nxt = S_DATA;
        S_DATA:   state_nxt = S_HASH;
        S_HASH:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // ---- output logic ----
  // Outputs decode from state only, so an asynchronous reset clears
  // out_valid in the same cycle and a stalled character cannot change.
  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state != S_IDLE);
    bus.out_last  = (state == S_HASH);
    bus.out_char  = 8'h00;
    case (state)
      S_CARET:  bus.out_char = 8'h5e;                    // '^'
      S_TIME:   bus.out_char = dec_char(time_nib);
      S_AT:     bus.out_char = 8'h40;                    // '@'
      S_PC:     bus.out_char = hex_char(nibble(pc_r, idx));
      S_COLON:  bus.out_char = 8'h3a;                    // ':'
      S_SPACE:  bus.out_char = 8'h20;
      S_SIGIL:  bus.out_char = kind_r ? 8'h2a : 8'h24;   // '*' or '$'
      S_REGNUM: bus.out_char = dec_char(grf_nib);
      S_ADDR:   bus.out_char = hex_char(nibble(addr_r, idx));
      S_ARROW: begin                                     // " <= "
        case (idx[1:0])
          2'd1:    bus.out_char = 8'h3c;
          2'd2:    bus.out_char = 8'h3d;
          default: bus.out_char = 8'h20;
        endcase
      end
      S_DATA:   bus.out_char = hex_char(nibble(data_r, idx));
      S_HASH:   bus.out_char = 8'h23;                    // '#'
      default:  bus.out_char = 8'h00;
    endcase
  end

endmodule

// File: doc/cpu_log_formatter.md
# cpu_log_formatter

Serialises one CPU write-back record per handshake into the ASCII trace-line format consumed by `cpu_checker`, emitting one character per accepted output beat. It sits between the CPU's commit/store port and the character stream bus, so that `cpu_checker` can check it directly in loop-back benches. Two record kinds are supported: register write (`$`) and memory write (`*`). Every emitted line is well-formed; field legality (PC range, alignment, grf range) is the checker's job, not this block's.

## Interface

- No parameters.
- `clk` input 1 — sole clock; all state updates on rising edge.
- `reset` input 1 — asynchronous, active-low; while 0 all state is at reset values.
- `in_valid` input 1 — record present on `in_*` fields.
- `in_ready` output 1 — block can accept a record; high only in IDLE.
- `in_kind` input 1 — 0 = register write (`$`), 1 = memory write (`*`).
- `in_time` input 14 — cycle stamp, printed in decimal.
- `in_pc` input 32 — printed as 8 lowercase hex digits.
- `in_grf` input 5 — register number, printed in decimal; used when `in_kind`=0.
- `in_addr` input 32 — memory address, printed as 8 hex digits; used when `in_kind`=1.
- `in_data` input 32 — written value, printed as 8 hex digits.
- `out_valid` output 1 — `out_char` is valid.
- `out_ready` input 1 — sink accepts the current character.
- `out_char` output 8 — ASCII character.
- `out_last` output 1 — high with the final `#` of a line.

## Operation

- Register line: `^` TIME `@` PC `:` ` ` `$` GRF ` <= ` DATA `#`.
- Memory line: `^` TIME `@` PC `:` ` ` `*` ADDR ` <= ` DATA `#`.
- TIME is decimal without leading zeros, 1–4 digits. Value 0 prints as `0`. Values >9999 clamp to `9999`.
- GRF is decimal without leading zeros, 1–2 digits (0..31).
- Hex fields are always 8 digits, MSB first, leading zeros kept, `a`–`f` lowercase.
- Line length: register line = 26+T+G characters; memory line = 34+T characters (T = TIME digits, G = GRF digits).
- All `in_*` fields are latched on acceptance (`in_valid && in_ready`). Later changes on the inputs do not affect the line in flight.
- Decimal digits come from the latched value. Combinational constant divide/modulo or a precomputed BCD register are both acceptable, provided the timing below holds.
- FSM states: IDLE → CARET → TIME → AT → PC → COLON → SPACE → SIGIL → (REGNUM | ADDR) → ARROW → DATA → HASH → IDLE.
- A 3-bit digit index serves TIME, PC, REGNUM, ADDR, ARROW (4 chars) and DATA. It resets to 0 on every state change.
- TIME starts at the first significant digit; leading zeros are skipped with no beat spent on them. REGNUM is handled the same way.
- `in_ready` = (state == IDLE).

## Timing

- Reset values: `out_valid`=0, `out_char`=8'h00, `out_last`=0, `in_ready`=1, state IDLE, index 0.
- Acceptance at edge N: `out_valid`=1 with `^` from cycle N+1.
- Each character is held stable (`out_char`, `out_last`) until the edge where `out_valid && out_ready`. The next character appears the following cycle, so the block can sustain 1 char/cycle with no bubbles inside a line.
- After `#` is accepted: `out_valid`=0 and `in_ready`=1 in the next cycle. There is no overlap between lines, so minimum spacing is line length + 1 cycle.
- `out_ready` low stalls indefinitely with no data change.
- `out_valid` never drops mid-line except on reset.
- `in_valid` while busy is ignored: not latched, not queued.
- Reset asserted mid-line: `out_valid`=0 immediately (asynchronous). The partial line is abandoned. After release the block is in IDLE; the next line begins with a fresh `^`.

## Test plan

- Reg write: time=1, pc=0x3000, grf=1, data=0xa, sink always ready → `^1@00003000: $1 <= 0000000a#`. 28 beats on consecutive cycles; `out_last` only on `#`; `in_ready` high 29 cycles after acceptance.
- Mem write: time=9999, pc=0x4ffc, addr=0x2ffc, data=0xdeadbeef → `^9999@00004ffc: *00002ffc <= deadbeef#` (38 chars).
- Decimal edges: time=0/grf=0 → `^0@…$0 <= …#`. time=10000 → `9999`. grf=31 → `$31`. time=1000 → `1000`, zeros kept inside the number.
- Backpressure: random `out_ready` (≈50%) over 200 random records. The concatenated stream is accepted by `cpu_checker` with format_type matching `in_kind`. The checker's error_code is compared against an independent model of field legality.
- Busy input: `in_valid` held high with changing fields during a line → only the first record is emitted. The second is taken exactly on the IDLE cycle.
- Reset at char 12: `out_valid`=0 within the same cycle. After release, record time=5 emits a complete `^5@…#` line with no residue.
